ssio_sdr_in_gearbox: RTL and testbench

Parametrised source-synchronous SDR input capture with a built-in 1:RATIO gearbox and word alignment. Each clk edge captures WIDTH lanes in an IOB register, applies an optional per-lane inversion and extra pipeline stages, then assembles RATIO consecutive samples into one WIDTH*RATIO-bit word. Word boundaries are aligned by hunting for SYNC_WORD. Sits directly behind the PHY/ADC pins and feeds the MAC/framer in the same rx clock domain.

---
 rtl/ssio_sdr_in_gearbox_if.sv | 25 ++
 rtl/ssio_sdr_in_gearbox.sv | 148 ++++++++++++++
 tb/tb_ssio_sdr_in_gearbox.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssio_sdr_in_gearbox_if.sv
// Pin-side capture and word-side stream signals of the SDR input gearbox.
// The master side drives pins and align_req; the slave side is the gearbox itself.
interface ssio_sdr_in_gearbox_if #(
  parameter int WIDTH = 2,
  parameter int RATIO = 4
);
  logic [WIDTH-1:0]       input_d;
  logic                   align_req;
  logic [WIDTH*RATIO-1:0] output_tdata;
  logic                   output_tvalid;
  logic                   output_tsync;
  logic                   locked;
  logic                   hunt_timeout;
  logic [15:0]            misalign_count;

  modport master (
    output input_d, align_req,
    input  output_tdata, output_tvalid, output_tsync, locked, hunt_timeout, misalign_count
  );

  modport slave (
    input  input_d, align_req,
    output output_tdata, output_tvalid, output_tsync, locked, hunt_timeout, misalign_count
  );
endinterface

// File: rtl/ssio_sdr_in_gearbox.sv
// Source-synchronous SDR capture with 1:RATIO gearbox and SYNC_WORD alignment.
// Optional SSIO_SDR_IN_MISALIGN_CNT_EN enables the off-phase sync counter.
module ssio_sdr_in_gearbox #(
  parameter int                       WIDTH        = 2,
  parameter int                       RATIO        = 4,
  parameter int                       PIPELINE     = 0,
  parameter logic [WIDTH-1:0]         INVERT_MASK  = '0,
  parameter logic [WIDTH*RATIO-1:0]   SYNC_WORD    = (WIDTH*RATIO)'(8'hD5),
  parameter int                       HUNT_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  ssio_sdr_in_gearbox_if.slave  bus
);

  localparam int WW = WIDTH * RATIO;
  localparam int PW = $clog2(RATIO);
  localparam int TW = (HUNT_TIMEOUT > 1) ? $clog2(HUNT_TIMEOUT) : 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  logic [WIDTH-1:0] iob_p0;
  logic [WIDTH-1:0] dly_p1 [PIPELINE+1];
  logic [WW-1:0]    win_p2;
  logic             win_match;

  state_t           state, state_nxt;
  logic [PW-1:0]    phase_cnt;
  logic [PW-1:0]    align_phase, align_phase_nxt;
  logic [TW-1:0]    tcnt, tcnt_nxt;

  logic [WW-1:0]    tdata_p3, tdata_nxt;
  logic             vld_p3, vld_nxt;
  logic             tsync_p3, tsync_nxt;
  logic             hto_p3, hto_nxt;

  // Stage p0: raw IOB capture; p1: inversion plus optional delay; p2: sample window
  always_ff @(posedge clk) begin
    if (rst) begin
      iob_p0 <= '0;
      for (int i = 0; i <= PIPELINE; i++) dly_p1[i] <= '0;
      win_p2 <= '0;
    end else begin
      iob_p0    <= bus.input_d;
      dly_p1[0] <= iob_p0 ^ INVERT_MASK;
      for (int i = 1; i <= PIPELINE; i++) dly_p1[i] <= dly_p1[i-1];
      win_p2    <= {dly_p1[PIPELINE], win_p2[WW-1:WIDTH]};
    end
  end

  assign win_match = (win_p2 == SYNC_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= (phase_cnt == PW'(RATIO-1)) ? '0 : phase_cnt + 1'b1;
    end
  end

  // Stage p3: alignment FSM and word output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      align_phase <= '0;
      tcnt        <= '0;
      tdata_p3    <= '0;
      vld_p3      <= 1'b0;
      tsync_p3    <= 1'b0;
      hto_p3      <= 1'b0;
    end else begin
      state       <= state_nxt;
      align_phase <= align_phase_nxt;
      tcnt        <= tcnt_nxt;
      tdata_p3    <= tdata_nxt;
      vld_p3      <= vld_nxt;
      tsync_p3    <= tsync_nxt;
      hto_p3      <= hto_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    align_phase_nxt = align_phase;
    tcnt_nxt        = tcnt;
    tdata_nxt       = tdata_p3;
    vld_nxt         = 1'b0;
    tsync_nxt       = 1'b0;
    hto_nxt         = 1'b0;
    if (bus.align_req) begin
      // A re-hunt request overrides any match or word due this cycle
      state_nxt = HUNT;
      tcnt_nxt  = '0;
    end else begin
      case (state)
        HUNT: begin
          if (win_match) begin
            state_nxt       = LOCKED;
            align_phase_nxt = phase_cnt;
            tcnt_nxt        = '0;
            tdata_nxt       = win_p2;
            vld_nxt         = 1'b1;
            tsync_nxt       = 1'b1;
          end else if (HUNT_TIMEOUT != 0) begin
            if (tcnt == TW'(HUNT_TIMEOUT-1)) begin
              tcnt_nxt = '0;
              hto_nxt  = 1'b1;
            end else begin
              tcnt_nxt = tcnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (phase_cnt == align_phase) begin
            tdata_nxt = win_p2;
            vld_nxt   = 1'b1;
            tsync_nxt = win_match;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

`ifdef SSIO_SDR_IN_MISALIGN_CNT_EN
  logic [15:0] mis_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_cnt <= '0;
    end else if (state == LOCKED && win_match && phase_cnt != align_phase &&
                 mis_cnt != 16'hFFFF) begin
      mis_cnt <= mis_cnt + 16'd1;
    end
  end

  assign bus.misalign_count = mis_cnt;
`else
  assign bus.misalign_count = 16'h0000;
`endif

  assign bus.output_tdata  = tdata_p3;
  assign bus.output_tvalid = vld_p3;
  assign bus.output_tsync  = tsync_p3;
  assign bus.locked        = (state == LOCKED);
  assign bus.hunt_timeout  = hto_p3;

endmodule

// File: tb/tb_ssio_sdr_in_gearbox.sv
// Bench for ssio_sdr_in_gearbox: two instances (PIPELINE=0 / PIPELINE=2 with inversion)
// checked every cycle against a sample-history reference model plus directed checkpoints.
module tb_ssio_sdr_in_gearbox;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] din  [2];
  logic       areq [2];
  int         vec  = 0;
  int         errs = 0;

  always #5 clk = ~clk;

  ssio_sdr_in_gearbox_if #(.WIDTH(2), .RATIO(4)) bus_a ();
  ssio_sdr_in_gearbox_if #(.WIDTH(2), .RATIO(4)) bus_b ();

  assign bus_a.input_d   = din[0];
  assign bus_a.align_req = areq[0];
  assign bus_b.input_d   = din[1];
  assign bus_b.align_req = areq[1];

  ssio_sdr_in_gearbox #(
    .WIDTH(2), .RATIO(4), .PIPELINE(0), .INVERT_MASK(2'b00),
    .SYNC_WORD(8'hD5), .HUNT_TIMEOUT(16)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  ssio_sdr_in_gearbox #(
    .WIDTH(2), .RATIO(4), .PIPELINE(2), .INVERT_MASK(2'b01),
    .SYNC_WORD(8'hD5), .HUNT_TIMEOUT(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Reference model: history of post-inversion samples, word framing by modular phase
  int         m_p    [2] = '{0, 2};
  logic [1:0] m_mask [2] = '{2'b00, 2'b01};
  int         m_to   [2] = '{16, 0};
  logic [1:0] hist   [2][8192];
  int         hn     [2];
  int         m_st   [2];
  int         m_ph   [2];
  int         m_ap   [2];
  int         m_tc   [2];
  logic [7:0]  e_td [2];
  logic        e_tv [2];
  logic        e_ts [2];
  logic        e_lk [2];
  logic        e_to [2];
  logic [15:0] e_mc [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d);
    int         n;
    logic [7:0] win;
    logic       match;
    logic       mis_now;
    if (rst) begin
      hn[d] = 0;
      for (int i = 0; i < 4 + 1 + m_p[d]; i++) begin
        hist[d][hn[d]] = 2'b00;
        hn[d]++;
      end
      hist[d][hn[d]] = m_mask[d];
      hn[d]++;
      m_st[d] = 0; m_ph[d] = 0; m_ap[d] = 0; m_tc[d] = 0;
      e_td[d] = '0; e_tv[d] = 0; e_ts[d] = 0; e_lk[d] = 0; e_to[d] = 0; e_mc[d] = '0;
    end else begin
      n = hn[d];
      for (int i = 0; i < 4; i++) win[2*i +: 2] = hist[d][n - 6 - m_p[d] + i];
      match   = (win == 8'hD5);
      mis_now = (m_st[d] == 1) && match && (m_ph[d] != m_ap[d]);
      e_tv[d] = 0; e_ts[d] = 0; e_to[d] = 0;
      if (areq[d]) begin
        m_st[d] = 0;
        m_tc[d] = 0;
      end else if (m_st[d] == 0) begin
        if (match) begin
          m_ap[d] = m_ph[d];
          m_st[d] = 1;
          m_tc[d] = 0;
          e_tv[d] = 1; e_ts[d] = 1; e_td[d] = win;
        end else if (m_to[d] != 0) begin
          m_tc[d]++;
          if (m_tc[d] == m_to[d]) begin
            e_to[d] = 1;
            m_tc[d] = 0;
          end
        end
      end else if (m_ph[d] == m_ap[d]) begin
        e_tv[d] = 1; e_td[d] = win; e_ts[d] = match;
      end
`ifdef SSIO_SDR_IN_MISALIGN_CNT_EN
      if (mis_now && e_mc[d] != 16'hFFFF) e_mc[d]++;
`else
      if (mis_now) e_mc[d] = 16'h0000;
`endif
      e_lk[d] = (m_st[d] == 1);
      m_ph[d] = (m_ph[d] + 1) % 4;
      hist[d][hn[d]] = din[d] ^ m_mask[d];
      hn[d]++;
    end
  endtask

  task automatic check_all();
    chk("a_tvalid", 16'(bus_a.output_tvalid),  16'(e_tv[0]));
    chk("a_tdata",  16'(bus_a.output_tdata),   16'(e_td[0]));
    chk("a_tsync",  16'(bus_a.output_tsync),   16'(e_ts[0]));
    chk("a_locked", 16'(bus_a.locked),         16'(e_lk[0]));
    chk("a_tmo",    16'(bus_a.hunt_timeout),   16'(e_to[0]));
    chk("a_miscnt", bus_a.misalign_count,      e_mc[0]);
    chk("b_tvalid", 16'(bus_b.output_tvalid),  16'(e_tv[1]));
    chk("b_tdata",  16'(bus_b.output_tdata),   16'(e_td[1]));
    chk("b_tsync",  16'(bus_b.output_tsync),   16'(e_ts[1]));
    chk("b_locked", 16'(bus_b.locked),         16'(e_lk[1]));
    chk("b_tmo",    16'(bus_b.hunt_timeout),   16'(e_to[1]));
    chk("b_miscnt", bus_b.misalign_count,      e_mc[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
    @(negedge clk);
  endtask

  function automatic logic [1:0] pat(input int d, input int i);
    if (d == 0) return (i == 3) ? 2'b11 : 2'b01;
    return (i == 3) ? 2'b10 : 2'b00;
  endfunction

  logic [1:0]  seq_a [16];
  logic [1:0]  seq_r [12];
  logic [1:0]  inj   [8];
  logic [15:0] exp_mc;
  int          pidx  [2];

  initial begin
    rst = 1'b1;
    din[0] = 2'b00; din[1] = 2'b00;
    areq[0] = 1'b0; areq[1] = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", 16'(bus_a.output_tvalid), 16'h0);
    chk("rst_locked", 16'(bus_a.locked), 16'h0);
    rst = 1'b0;

    // Hunt timeout every 16 cycles while no sync arrives
    for (int t = 1; t <= 48; t++) begin
      tick();
      chk("tmo_pulse", 16'(bus_a.hunt_timeout), 16'((t % 16) == 0));
      chk("tmo_locked", 16'(bus_a.locked), 16'h0);
      chk("tmo_tvalid", 16'(bus_a.output_tvalid), 16'h0);
    end

    // Alignment on the sync pattern, then one data word
    seq_a = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01,
              2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 16; i++) begin
      din[0] = seq_a[i];
      tick();
      if (i == 11) begin
        chk("align_tvalid", 16'(bus_a.output_tvalid), 16'h1);
        chk("align_tdata",  16'(bus_a.output_tdata),  16'h00D5);
        chk("align_tsync",  16'(bus_a.output_tsync),  16'h1);
        chk("align_locked", 16'(bus_a.locked),        16'h1);
      end
      if (i >= 12 && i <= 14) chk("align_gap", 16'(bus_a.output_tvalid), 16'h0);
      if (i == 15) begin
        chk("word2_tvalid", 16'(bus_a.output_tvalid), 16'h1);
        chk("word2_tdata",  16'(bus_a.output_tdata),  16'h00AA);
        chk("word2_tsync",  16'(bus_a.output_tsync),  16'h0);
      end
    end

    // Realign request, then sync shifted by one sample
    din[0] = 2'b00;
    areq[0] = 1'b1;
    tick();
    areq[0] = 1'b0;
    chk("realign_locked", 16'(bus_a.locked), 16'h0);
    chk("realign_tvalid", 16'(bus_a.output_tvalid), 16'h0);
    seq_r = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10,
              2'b10, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 12; i++) begin
      din[0] = seq_r[i];
      tick();
      if (i == 7) begin
        chk("relock_tdata",  16'(bus_a.output_tdata),  16'h00D5);
        chk("relock_tvalid", 16'(bus_a.output_tvalid), 16'h1);
        chk("relock_locked", 16'(bus_a.locked),        16'h1);
      end
      if (i == 11) chk("relock_word2", 16'(bus_a.output_tdata), 16'h00AA);
    end

    // Off-phase sync three times while locked
    din[0] = 2'b00;
    tick();
    inj = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        din[0] = inj[i];
        tick();
      end
    end
    din[0] = 2'b00;
    repeat (8) tick();
`ifdef SSIO_SDR_IN_MISALIGN_CNT_EN
    exp_mc = 16'd3;
`else
    exp_mc = 16'd0;
`endif
    chk("misalign_count", bus_a.misalign_count, exp_mc);
    chk("misalign_locked", 16'(bus_a.locked), 16'h1);

    // Reset held three cycles in the middle of traffic
    for (int i = 0; i < 10; i++) begin
      din[0] = 2'($urandom); din[1] = 2'($urandom);
      tick();
    end
    rst = 1'b1;
    repeat (3) tick();
    chk("mrst_a_tdata",  16'(bus_a.output_tdata),  16'h0);
    chk("mrst_a_tvalid", 16'(bus_a.output_tvalid), 16'h0);
    chk("mrst_a_locked", 16'(bus_a.locked),        16'h0);
    chk("mrst_a_miscnt", bus_a.misalign_count,     16'h0);
    chk("mrst_b_tdata",  16'(bus_b.output_tdata),  16'h0);
    chk("mrst_b_locked", 16'(bus_b.locked),        16'h0);
    rst = 1'b0;

    // Deeper pipeline with lane-0 inversion: lock then constant zeros give 0x55
    din[0] = 2'b00;
    for (int i = 0; i < 24; i++) begin
      din[1] = (i >= 5 && i <= 8) ? pat(1, i - 5) : 2'b00;
      tick();
      if (i == 13) begin
        chk("pipe_lock_tvalid", 16'(bus_b.output_tvalid), 16'h1);
        chk("pipe_lock_tdata",  16'(bus_b.output_tdata),  16'h00D5);
        chk("pipe_lock_locked", 16'(bus_b.locked),        16'h1);
      end
      if (i >= 14 && i <= 16) chk("pipe_gap", 16'(bus_b.output_tvalid), 16'h0);
      if (i == 17 || i == 21) begin
        chk("pipe_tvalid", 16'(bus_b.output_tvalid), 16'h1);
        chk("pipe_tdata",  16'(bus_b.output_tdata),  16'h0055);
        chk("pipe_tsync",  16'(bus_b.output_tsync),  16'h0);
      end
    end

    // Randomized traffic with injected sync patterns, realign requests and resets
    pidx[0] = -1; pidx[1] = -1;
    for (int t = 0; t < 1500; t++) begin
      for (int d = 0; d < 2; d++) begin
        if (pidx[d] < 0 && $urandom_range(0, 7) == 0) pidx[d] = 0;
        if (pidx[d] >= 0) begin
          din[d]  = pat(d, pidx[d]);
          pidx[d] = (pidx[d] == 3) ? -1 : pidx[d] + 1;
        end else begin
          din[d] = 2'($urandom);
        end
        areq[d] = ($urandom_range(0, 59) == 0);
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
